// File: rtl/axi_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_arb_pkg : AXI encodings and one-hot FSM state types for the SDRAM arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package axi_arb_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef enum logic [2:0] {
    R_IDLE = 3'b001,
    R_ADDR = 3'b010,
    R_DATA = 3'b100
  } r_state_e;

  typedef enum logic [3:0] {
    W_IDLE = 4'b0001,
    W_ADDR = 4'b0010,
    W_DATA = 4'b0100,
    W_RESP = 4'b1000
  } w_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb2 : two-requester arbiter, round-robin or fixed (req[1] wins) mode
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_rr_mode,
  input  logic       i_update,
  input  logic       i_last_gnt1,
  output logic [1:0] o_gnt
);

  // ptr_q = 1 means requester 1 wins the next tie
  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (i_update) ptr_d = ~i_last_gnt1;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (i_rr_mode && !ptr_q) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/axi_sdram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_sdram_arbiter : IFU(read) + LSU(read/write) to single SDRAM AXI4 slave
// Rev 1.0
// ---------------------------------------------------------------------------
module axi_sdram_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int RR     = 1,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  output logic              m0_rvalid,
  output logic              m0_rlast,
  output logic [1:0]        m0_rresp,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m0_rready,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  output logic              m1_rvalid,
  output logic              m1_rlast,
  output logic [1:0]        m1_rresp,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              m1_rready,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic [7:0]        m1_awlen,
  input  logic [2:0]        m1_awsize,
  input  logic [1:0]        m1_awburst,
  input  logic              m1_wvalid,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  input  logic              m1_wlast,
  output logic              m1_wready,
  output logic              m1_bvalid,
  output logic [1:0]        m1_bresp,
  input  logic              m1_bready,
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  input  logic              s_rvalid,
  input  logic              s_rlast,
  input  logic [1:0]        s_rresp,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              s_rready,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic [7:0]        s_awlen,
  output logic [2:0]        s_awsize,
  output logic [1:0]        s_awburst,
  output logic              s_wvalid,
  input  logic              s_wready,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  output logic              s_wlast,
  input  logic              s_bvalid,
  input  logic [1:0]        s_bresp,
  output logic              s_bready,
  output logic              wlast_err
);

  r_state_e          r_state_q, r_state_d;
  logic              gnt1_q, gnt1_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic [7:0]        ar_len_q, ar_len_d;
  logic [2:0]        ar_size_q, ar_size_d;
  logic [1:0]        ar_burst_q, ar_burst_d;
  w_state_e          w_state_q, w_state_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]        aw_len_q, aw_len_d;
  logic [2:0]        aw_size_q, aw_size_d;
  logic [1:0]        aw_burst_q, aw_burst_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic              wlast_err_q, wlast_err_d;
  logic [1:0]        arb_gnt;
  logic              arb_update;
  logic              to_m0, to_m1, wr_active, resp_active;

  rr_arb2 u_arb (
    .clk         (clk),
    .rst_n       (rst),
    .i_req       ({m1_arvalid, m0_arvalid}),
    .i_rr_mode   (RR != 0),
    .i_update    (arb_update),
    .i_last_gnt1 (gnt1_q),
    .o_gnt       (arb_gnt)
  );

  always_comb begin
    r_state_d  = r_state_q;
    gnt1_d     = gnt1_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    arb_update = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        // ready is masked while reset is held so nothing looks accepted
        m0_arready = rst & arb_gnt[0];
        m1_arready = rst & arb_gnt[1];
        if (arb_gnt != 2'b00) begin
          r_state_d  = R_ADDR;
          gnt1_d     = arb_gnt[1];
          ar_addr_d  = arb_gnt[1] ? m1_araddr  : m0_araddr;
          ar_len_d   = arb_gnt[1] ? m1_arlen   : m0_arlen;
          ar_size_d  = arb_gnt[1] ? m1_arsize  : m0_arsize;
          ar_burst_d = arb_gnt[1] ? m1_arburst : m0_arburst;
        end
      end
      R_ADDR: if (s_arready) r_state_d = R_DATA;
      R_DATA: begin
        if (s_rvalid && s_rready && s_rlast) begin
          r_state_d  = R_IDLE;
          arb_update = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d   = w_state_q;
    aw_addr_d   = aw_addr_q;
    aw_len_d    = aw_len_q;
    aw_size_d   = aw_size_q;
    aw_burst_d  = aw_burst_q;
    beat_cnt_d  = beat_cnt_q;
    wlast_err_d = wlast_err_q;
    case (w_state_q)
      W_IDLE: begin
        if (m1_awvalid) begin
          w_state_d  = W_ADDR;
          aw_addr_d  = m1_awaddr;
          aw_len_d   = m1_awlen;
          aw_size_d  = m1_awsize;
          aw_burst_d = m1_awburst;
          beat_cnt_d = 8'd0;
        end
      end
      W_ADDR: if (s_awready) w_state_d = W_DATA;
      W_DATA: begin
        if (m1_wvalid && s_wready) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          // error whenever wlast and "count reached awlen" disagree
          if (m1_wlast != (beat_cnt_q == aw_len_q)) wlast_err_d = 1'b1;
          if (m1_wlast) w_state_d = W_RESP;
        end
      end
      W_RESP: if (s_bvalid && m1_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q   <= R_IDLE;
      gnt1_q      <= 1'b0;
      ar_addr_q   <= '0;
      ar_len_q    <= '0;
      ar_size_q   <= '0;
      ar_burst_q  <= '0;
      w_state_q   <= W_IDLE;
      aw_addr_q   <= '0;
      aw_len_q    <= '0;
      aw_size_q   <= '0;
      aw_burst_q  <= '0;
      beat_cnt_q  <= '0;
      wlast_err_q <= 1'b0;
    end else begin
      r_state_q   <= r_state_d;
      gnt1_q      <= gnt1_d;
      ar_addr_q   <= ar_addr_d;
      ar_len_q    <= ar_len_d;
      ar_size_q   <= ar_size_d;
      ar_burst_q  <= ar_burst_d;
      w_state_q   <= w_state_d;
      aw_addr_q   <= aw_addr_d;
      aw_len_q    <= aw_len_d;
      aw_size_q   <= aw_size_d;
      aw_burst_q  <= aw_burst_d;
      beat_cnt_q  <= beat_cnt_d;
      wlast_err_q <= wlast_err_d;
    end
  end

  assign s_arvalid = (r_state_q == R_ADDR);
  assign s_araddr  = ar_addr_q;
  assign s_arlen   = ar_len_q;
  assign s_arsize  = ar_size_q;
  assign s_arburst = ar_burst_q;

  assign to_m0     = (r_state_q == R_DATA) & ~gnt1_q;
  assign to_m1     = (r_state_q == R_DATA) &  gnt1_q;
  assign s_rready  = (to_m0 & m0_rready) | (to_m1 & m1_rready);
  assign m0_rvalid = to_m0 & s_rvalid;
  assign m0_rlast  = to_m0 & s_rlast;
  assign m0_rresp  = to_m0 ? s_rresp : RESP_OKAY;
  assign m0_rdata  = to_m0 ? s_rdata : '0;
  assign m1_rvalid = to_m1 & s_rvalid;
  assign m1_rlast  = to_m1 & s_rlast;
  assign m1_rresp  = to_m1 ? s_rresp : RESP_OKAY;
  assign m1_rdata  = to_m1 ? s_rdata : '0;

  assign m1_awready  = rst & (w_state_q == W_IDLE);
  assign s_awvalid   = (w_state_q == W_ADDR);
  assign s_awaddr    = aw_addr_q;
  assign s_awlen     = aw_len_q;
  assign s_awsize    = aw_size_q;
  assign s_awburst   = aw_burst_q;
  assign wr_active   = (w_state_q == W_DATA);
  assign s_wvalid    = wr_active & m1_wvalid;
  assign m1_wready   = wr_active & s_wready;
  assign s_wdata     = wr_active ? m1_wdata : '0;
  assign s_wstrb     = wr_active ? m1_wstrb : '0;
  assign s_wlast     = wr_active & m1_wlast;
  assign resp_active = (w_state_q == W_RESP);
  assign m1_bvalid   = resp_active & s_bvalid;
  assign m1_bresp    = resp_active ? s_bresp : RESP_OKAY;
  assign s_bready    = resp_active & m1_bready;
  assign wlast_err   = wlast_err_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_sdram_arbiter.sv
`default_nettype none
// tb_axi_sdram_arbiter : directed bench with a small behavioural SDRAM slave.
module tb_axi_sdram_arbiter;
  import axi_arb_pkg::*;

  logic        clk = 1'b0, rst = 1'b0;
  logic        m0_arvalid = 0, m0_arready, m0_rvalid, m0_rlast, m0_rready = 1;
  logic [31:0] m0_araddr = '0;
  logic [7:0]  m0_arlen = '0;
  logic [2:0]  m0_arsize = 3'd3;
  logic [1:0]  m0_arburst = BURST_INCR, m0_rresp;
  logic [63:0] m0_rdata;
  logic        m1_arvalid = 0, m1_arready, m1_rvalid, m1_rlast, m1_rready = 1;
  logic [31:0] m1_araddr = '0;
  logic [7:0]  m1_arlen = '0;
  logic [2:0]  m1_arsize = 3'd3;
  logic [1:0]  m1_arburst = BURST_INCR, m1_rresp;
  logic [63:0] m1_rdata;
  logic        m1_awvalid = 0, m1_awready, m1_wvalid = 0, m1_wlast = 0, m1_wready;
  logic [31:0] m1_awaddr = '0;
  logic [7:0]  m1_awlen = '0, m1_wstrb = '0;
  logic [2:0]  m1_awsize = 3'd3;
  logic [1:0]  m1_awburst = BURST_INCR, m1_bresp;
  logic [63:0] m1_wdata = '0;
  logic        m1_bvalid, m1_bready = 1;
  logic        s_arvalid, s_rvalid = 0, s_rlast = 0, s_rready, s_awvalid, s_wvalid, s_wlast;
  logic        s_bvalid = 0, s_bready, wlast_err;
  logic [31:0] s_araddr, s_awaddr;
  logic [7:0]  s_arlen, s_awlen, s_wstrb;
  logic [2:0]  s_arsize, s_awsize;
  logic [1:0]  s_arburst, s_awburst;
  logic [63:0] s_rdata = '0, s_wdata;

  // outputs of the fixed-priority instance
  logic        fx_req = 1'b0;
  logic        f_m0_arready, f_m0_rvalid, f_m0_rlast, f_m1_arready, f_m1_rvalid, f_m1_rlast;
  logic        f_m1_awready, f_m1_wready, f_m1_bvalid, f_s_arvalid, f_s_rready, f_s_awvalid;
  logic        f_s_wvalid, f_s_wlast, f_s_bready, f_wlast_err;
  logic [1:0]  f_m0_rresp, f_m1_rresp, f_m1_bresp, f_s_arburst, f_s_awburst;
  logic [63:0] f_m0_rdata, f_m1_rdata, f_s_wdata;
  logic [31:0] f_s_araddr, f_s_awaddr;
  logic [7:0]  f_s_arlen, f_s_awlen, f_s_wstrb;
  logic [2:0]  f_s_arsize, f_s_awsize;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  axi_sdram_arbiter #(.ADDR_W(32), .DATA_W(64), .RR(1)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
    .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_rvalid(m0_rvalid), .m0_rlast(m0_rlast),
    .m0_rresp(m0_rresp), .m0_rdata(m0_rdata), .m0_rready(m0_rready),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
    .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_rvalid(m1_rvalid), .m1_rlast(m1_rlast),
    .m1_rresp(m1_rresp), .m1_rdata(m1_rdata), .m1_rready(m1_rready),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen),
    .m1_awsize(m1_awsize), .m1_awburst(m1_awburst), .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast), .m1_wready(m1_wready), .m1_bvalid(m1_bvalid),
    .m1_bresp(m1_bresp), .m1_bready(m1_bready),
    .s_arvalid(s_arvalid), .s_arready(1'b1), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_rvalid(s_rvalid), .s_rlast(s_rlast),
    .s_rresp(2'b00), .s_rdata(s_rdata), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awready(1'b1), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst), .s_wvalid(s_wvalid), .s_wready(1'b1),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_bvalid(s_bvalid),
    .s_bresp(2'b00), .s_bready(s_bready), .wlast_err(wlast_err)
  );

  // fixed-priority instance: both masters always request, slave answers instantly
  axi_sdram_arbiter #(.ADDR_W(32), .DATA_W(64), .RR(0)) dut_fix (
    .clk(clk), .rst(rst),
    .m0_arvalid(fx_req), .m0_arready(f_m0_arready), .m0_araddr(32'h0), .m0_arlen(8'h0),
    .m0_arsize(3'd3), .m0_arburst(2'b01), .m0_rvalid(f_m0_rvalid), .m0_rlast(f_m0_rlast),
    .m0_rresp(f_m0_rresp), .m0_rdata(f_m0_rdata), .m0_rready(1'b1),
    .m1_arvalid(fx_req), .m1_arready(f_m1_arready), .m1_araddr(32'h0), .m1_arlen(8'h0),
    .m1_arsize(3'd3), .m1_arburst(2'b01), .m1_rvalid(f_m1_rvalid), .m1_rlast(f_m1_rlast),
    .m1_rresp(f_m1_rresp), .m1_rdata(f_m1_rdata), .m1_rready(1'b1),
    .m1_awvalid(1'b0), .m1_awready(f_m1_awready), .m1_awaddr(32'h0), .m1_awlen(8'h0),
    .m1_awsize(3'd3), .m1_awburst(2'b01), .m1_wvalid(1'b0), .m1_wdata(64'h0),
    .m1_wstrb(8'h0), .m1_wlast(1'b0), .m1_wready(f_m1_wready), .m1_bvalid(f_m1_bvalid),
    .m1_bresp(f_m1_bresp), .m1_bready(1'b1),
    .s_arvalid(f_s_arvalid), .s_arready(1'b1), .s_araddr(f_s_araddr), .s_arlen(f_s_arlen),
    .s_arsize(f_s_arsize), .s_arburst(f_s_arburst), .s_rvalid(1'b1), .s_rlast(1'b1),
    .s_rresp(2'b00), .s_rdata(64'h0), .s_rready(f_s_rready),
    .s_awvalid(f_s_awvalid), .s_awready(1'b1), .s_awaddr(f_s_awaddr), .s_awlen(f_s_awlen),
    .s_awsize(f_s_awsize), .s_awburst(f_s_awburst), .s_wvalid(f_s_wvalid), .s_wready(1'b1),
    .s_wdata(f_s_wdata), .s_wstrb(f_s_wstrb), .s_wlast(f_s_wlast), .s_bvalid(1'b0),
    .s_bresp(2'b00), .s_bready(f_s_bready), .wlast_err(f_wlast_err)
  );

  // slave model and beat monitor: sample just before the edge, update just after
  logic [31:0] rd_addr = '0;
  logic [7:0]  rd_len = '0, rd_beat = '0;
  logic        rd_pend = 0, b_pend = 0;
  logic [63:0] r0log [64];
  logic [63:0] wlog_d [16];
  logic        wlog_l [16];
  int r0n = 0, r0b = 0, r1b = 0, wn = 0, m1v_cnt = 0, fg0 = 0, fg1 = 0;

  initial begin
    logic ar_hs, r_hs, w_hs, b_hs, wl, m0b, m0l, m1b, m1l, m1v, f0, f1;
    logic [63:0] wd, m0d;
    logic [31:0] aa;
    logic [7:0]  al;
    forever begin
      @(negedge clk); #4;
      ar_hs = s_arvalid; aa = s_araddr; al = s_arlen;
      r_hs = s_rvalid & s_rready; w_hs = s_wvalid; wl = s_wlast; wd = s_wdata;
      b_hs = s_bvalid & s_bready;
      m0b = m0_rvalid & m0_rready; m0l = m0_rlast; m0d = m0_rdata;
      m1b = m1_rvalid & m1_rready; m1l = m1_rlast; m1v = m1_rvalid;
      f0 = fx_req & f_m0_arready; f1 = fx_req & f_m1_arready;
      @(posedge clk); #1;
      if (!rst) begin
        rd_pend = 0; b_pend = 0;
      end else begin
        if (r_hs) begin
          if (rd_beat == rd_len) rd_pend = 0;
          else rd_beat = rd_beat + 8'd1;
        end
        if (ar_hs) begin rd_pend = 1; rd_addr = aa; rd_len = al; rd_beat = 0; end
        if (w_hs) begin wlog_d[wn] = wd; wlog_l[wn] = wl; wn++; if (wl) b_pend = 1; end
        if (b_hs) b_pend = 0;
        if (m0b) begin r0log[r0n] = m0d; r0n++; if (m0l) r0b++; end
        if (m1b && m1l) r1b++;
        if (m1v) m1v_cnt++;
        if (f0) fg0++;
        if (f1) fg1++;
      end
      s_rvalid = rd_pend;
      s_rdata  = 64'(rd_addr) + 64'(rd_beat);
      s_rlast  = (rd_beat == rd_len);
      s_bvalid = b_pend;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd0(input logic [31:0] addr, input logic [7:0] len, input bit tog);
    int t, s0, bs;
    logic got;
    s0 = r0n; bs = r0b;
    m0_araddr = addr; m0_arlen = len; m0_arvalid = 1;
    got = 0; t = 0;
    while (!got && t < 50) begin
      @(negedge clk); #4; got = m0_arvalid & m0_arready;
      @(posedge clk); #1; t++;
    end
    m0_arvalid = 0;
    chk("m0_ar_handshake", got, 1);
    chk("s_arvalid_lat1", s_arvalid, 1);
    chk("s_araddr", s_araddr, addr);
    chk("s_arlen", s_arlen, len);
    t = 0;
    while (r0b == bs && t < 300) begin
      @(posedge clk); #1; t++;
      if (tog) m0_rready = ~m0_rready;
    end
    m0_rready = 1;
    chk("m0_burst_done", r0b != bs, 1);
    chk("m0_beat_count", r0n - s0, len + 1);
    for (int k = 0; k <= int'(len); k++) chk("m0_rdata", r0log[s0 + k], 64'(addr) + 64'(k));
  endtask

  task automatic wr(input logic [31:0] addr, input logic [7:0] len, input int nb);
    int t, ws;
    logic got;
    logic [7:0] bt;
    ws = wn;
    m1_awaddr = addr; m1_awlen = len; m1_awvalid = 1;
    got = 0; t = 0;
    while (!got && t < 50) begin
      @(negedge clk); #4; got = m1_awvalid & m1_awready;
      @(posedge clk); #1; t++;
    end
    m1_awvalid = 0;
    chk("m1_aw_handshake", got, 1);
    chk("s_awvalid", s_awvalid, 1);
    chk("s_awaddr", s_awaddr, addr);
    for (int i = 0; i < nb; i++) begin
      bt = 8'h11 * 8'(i + 1);
      m1_wvalid = 1; m1_wdata = {8{bt}}; m1_wstrb = 8'hFF; m1_wlast = (i == nb - 1);
      got = 0; t = 0;
      while (!got && t < 50) begin
        @(negedge clk); #4; got = m1_wvalid & m1_wready;
        @(posedge clk); #1; t++;
      end
      chk("m1_w_handshake", got, 1);
    end
    m1_wvalid = 0; m1_wlast = 0;
    got = 0; t = 0;
    while (!got && t < 50) begin
      @(negedge clk); #4; got = m1_bvalid & m1_bready;
      @(posedge clk); #1; t++;
    end
    chk("m1_b_handshake", got, 1);
    chk("s_w_beat_count", wn - ws, nb);
    for (int i = 0; i < nb; i++) begin
      bt = 8'h11 * 8'(i + 1);
      chk("s_wdata", wlog_d[ws + i], {8{bt}});
      chk("s_wlast", wlog_l[ws + i], (i == nb - 1));
    end
  endtask

  initial begin
    int t, n, v0;
    logic g0, g1;
    logic ord [4];
    m0_araddr = 32'h100; m1_araddr = 32'h200;
    m0_arvalid = 1; m1_arvalid = 1;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_m0_arready", m0_arready, 0);
    chk("rst_m1_arready", m1_arready, 0);
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_m1_awready", m1_awready, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_wlast_err", wlast_err, 0);
    rst = 1; #2;
    chk("first_gnt_m0", m0_arready, 1);
    chk("first_gnt_not_m1", m1_arready, 0);

    n = 0; t = 0;
    while (n < 4 && t < 100) begin
      @(negedge clk); #4; g0 = m0_arvalid & m0_arready; g1 = m1_arvalid & m1_arready;
      @(posedge clk); #1; t++;
      if (g0 || g1) begin ord[n] = g1; n++; end
      if (n == 4) begin m0_arvalid = 0; m1_arvalid = 0; end
    end
    chk("rr_grant_count", n, 4);
    t = 0;
    while ((r0b + r1b) < 4 && t < 100) begin @(posedge clk); #1; t++; end
    chk("rr_bursts_done", r0b + r1b, 4);
    chk("rr_order0_m0", ord[0], 0);
    chk("rr_order1_m1", ord[1], 1);
    chk("rr_order2_m0", ord[2], 0);
    chk("rr_order3_m1", ord[3], 1);

    fx_req = 1;
    repeat (20) begin @(posedge clk); #1; end
    fx_req = 0;
    chk("fixed_m0_never", fg0, 0);
    chk("fixed_m1_repeated", fg1 >= 3, 1);

    v0 = m1v_cnt;
    rd0(32'h8000_0000, 8'd3, 1'b0);
    chk("m1_rvalid_quiet", m1v_cnt - v0, 0);

    wr(32'h0000_1000, 8'd1, 2);
    chk("wlast_err_clean", wlast_err, 0);

    fork
      rd0(32'h0000_4000, 8'd7, 1'b1);
      wr(32'h0000_2000, 8'd1, 2);
    join
    chk("wlast_err_concurrent", wlast_err, 0);

    wr(32'h0000_3000, 8'd2, 1);
    chk("wlast_err_set", wlast_err, 1);
    @(posedge clk); #1;
    chk("w_back_to_idle", m1_awready, 1);
    wr(32'h0000_3100, 8'd0, 1);
    chk("wlast_err_sticky", wlast_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
